// File: rtl/scariv_sched_pkg.sv
// scariv_sched_pkg
//   Shared types and helpers for the issue entry scheduler.
//   - SCHED_DATA_W / SCHED_TAG_W : widths of the stored payload and wakeup tag
//   - sched_entry_t              : one scheduler slot {valid, ready, tag, data}
//   - occ_width()                : width of a counter that holds 0..n inclusive
package scariv_sched_pkg;

  localparam int SCHED_ENTRY_SIZE = 8;
  localparam int SCHED_ISS_PORTS  = 2;
  localparam int SCHED_DATA_W     = 32;
  localparam int SCHED_TAG_W      = 6;

  typedef struct packed {
    logic                    valid;
    logic                    ready;
    logic [SCHED_TAG_W-1:0]  tag;
    logic [SCHED_DATA_W-1:0] data;
  } sched_entry_t;

  // Bits needed to count from 0 up to and including n.
  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bit_pick_1_index.sv
// bit_pick_1_index
//   Combinational N-th-valid picker: finds the NUM-th set bit (counting from 0)
//   of i_valids, scanning from index 0 upward, and forwards that slot's data.
//   Ports:
//     i_valids      in  SEL_WIDTH               candidate bit vector
//     i_data        in  DATA_WIDTH x SEL_WIDTH  per-slot payload
//     o_valid       out 1                       an NUM-th set bit exists
//     o_data        out DATA_WIDTH              payload of the picked slot, 0 if none
//     o_picked_pos  out SEL_WIDTH               one-hot of the picked slot, 0 if none
module bit_pick_1_index #(
  parameter int NUM        = 0,
  parameter int SEL_WIDTH  = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic [SEL_WIDTH-1:0]  i_valids,
  input  logic [DATA_WIDTH-1:0] i_data [SEL_WIDTH],
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [SEL_WIDTH-1:0]  o_picked_pos
);

  int cnt;

  always_comb begin
    o_valid      = 1'b0;
    o_data       = '0;
    o_picked_pos = '0;
    cnt          = 0;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (i_valids[i] && !o_valid) begin
        if (cnt == NUM) begin
          o_valid         = 1'b1;
          o_data          = i_data[i];
          o_picked_pos[i] = 1'b1;
        end
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/issue_entry_scheduler.sv
// issue_entry_scheduler
//   Holds up to ENTRY_SIZE dispatched operations, each waiting on at most one
//   source tag, and issues up to ISS_PORTS ready operations per cycle. Port p
//   receives the p-th ready entry in index order (lowest index first).
//   Ports:
//     i_clk, i_reset_n        clock, asynchronous active-low reset
//     i_flush                 clear every entry on the next edge
//     i_alloc_*/o_alloc_ready dispatch handshake, payload and source tag
//     i_wakeup_valid/_tag     tag broadcast that marks waiting entries ready
//     o_iss_valid/o_iss_data  per-port issue offer; i_iss_ready accepts it
//     o_occupancy, o_empty    registered count of valid entries
module issue_entry_scheduler
  import scariv_sched_pkg::*;
#(
  parameter int ENTRY_SIZE = SCHED_ENTRY_SIZE,
  parameter int ISS_PORTS  = SCHED_ISS_PORTS,
  // Stored payload/tag widths come from sched_entry_t; keep these equal to
  // the package widths.
  parameter int DATA_WIDTH = SCHED_DATA_W,
  parameter int TAG_W      = SCHED_TAG_W,
  localparam int OCC_W     = occ_width(ENTRY_SIZE),
  localparam int IDX_W     = $clog2(ENTRY_SIZE)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_flush,
  input  logic                  i_alloc_valid,
  output logic                  o_alloc_ready,
  input  logic [DATA_WIDTH-1:0] i_alloc_data,
  input  logic                  i_alloc_src_ready,
  input  logic [TAG_W-1:0]      i_alloc_src_tag,
  input  logic                  i_wakeup_valid,
  input  logic [TAG_W-1:0]      i_wakeup_tag,
  output logic [ISS_PORTS-1:0]  o_iss_valid,
  output logic [DATA_WIDTH-1:0] o_iss_data [ISS_PORTS],
  input  logic [ISS_PORTS-1:0]  i_iss_ready,
  output logic [OCC_W-1:0]      o_occupancy,
  output logic                  o_empty
);

  sched_entry_t entry_q [ENTRY_SIZE];
  sched_entry_t entry_d [ENTRY_SIZE];
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [ENTRY_SIZE-1:0] valid_vec;
  logic [ENTRY_SIZE-1:0] rdy_vec;
  logic [DATA_WIDTH-1:0] entry_data [ENTRY_SIZE];
  logic [IDX_W-1:0]      idx_tbl    [ENTRY_SIZE];

  logic [ENTRY_SIZE-1:0] free_oh;
  logic [IDX_W-1:0]      free_idx;
  logic                  alloc_fire;
  logic                  alloc_src_rdy;

  logic [ISS_PORTS-1:0]  pick_valid;
  logic [ENTRY_SIZE-1:0] pick_oh [ISS_PORTS];
  logic [ISS_PORTS-1:0]  iss_fire;
  logic [ENTRY_SIZE-1:0] release_oh;
  logic [OCC_W-1:0]      fire_cnt;

  for (genvar gi = 0; gi < ENTRY_SIZE; gi++) begin : g_entry_view
    assign valid_vec[gi]  = entry_q[gi].valid;
    assign rdy_vec[gi]    = entry_q[gi].valid & entry_q[gi].ready;
    assign entry_data[gi] = entry_q[gi].data;
    assign idx_tbl[gi]    = IDX_W'(gi);
  end

  // Free-slot pick: lowest-index invalid entry. Its data output carries the
  // slot index, which is only used to cross-check the one-hot.
  bit_pick_1_index #(
    .NUM        (0),
    .SEL_WIDTH  (ENTRY_SIZE),
    .DATA_WIDTH (IDX_W)
  ) u_free_pick (
    .i_valids     (~valid_vec),
    .i_data       (idx_tbl),
    .o_valid      (o_alloc_ready),
    .o_data       (free_idx),
    .o_picked_pos (free_oh)
  );

  assign alloc_fire    = i_alloc_valid && o_alloc_ready && !i_flush;
  // A wakeup in the dispatch cycle would otherwise be missed by the new entry.
  assign alloc_src_rdy = i_alloc_src_ready ||
                         (i_wakeup_valid && (i_wakeup_tag == i_alloc_src_tag));

  for (genvar gi = 0; gi < ISS_PORTS; gi++) begin : g_iss_pick
    bit_pick_1_index #(
      .NUM        (gi),
      .SEL_WIDTH  (ENTRY_SIZE),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_iss_pick (
      .i_valids     (rdy_vec),
      .i_data       (entry_data),
      .o_valid      (pick_valid[gi]),
      .o_data       (o_iss_data[gi]),
      .o_picked_pos (pick_oh[gi])
    );
    assign o_iss_valid[gi] = pick_valid[gi] && !i_flush;
  end

  assign iss_fire = o_iss_valid & i_iss_ready;

  always_comb begin
    release_oh = '0;
    fire_cnt   = '0;
    for (int p = 0; p < ISS_PORTS; p++) begin
      if (iss_fire[p]) begin
        release_oh = release_oh | pick_oh[p];
      end
      fire_cnt = fire_cnt + OCC_W'(iss_fire[p]);
    end
  end

  // Entry next state. The allocation target is always a free slot, so it can
  // never coincide with a released one.
  always_comb begin
    for (int i = 0; i < ENTRY_SIZE; i++) begin
      entry_d[i] = entry_q[i];
      if (i_flush) begin
        entry_d[i] = '0;
      end else begin
        if (entry_q[i].valid && !entry_q[i].ready && i_wakeup_valid &&
            (entry_q[i].tag == i_wakeup_tag)) begin
          entry_d[i].ready = 1'b1;
        end
        if (release_oh[i]) begin
          entry_d[i].valid = 1'b0;
          entry_d[i].ready = 1'b0;
        end
        if (alloc_fire && free_oh[i]) begin
          entry_d[i].valid = 1'b1;
          entry_d[i].ready = alloc_src_rdy;
          entry_d[i].tag   = i_alloc_src_tag;
          entry_d[i].data  = i_alloc_data;
        end
      end
    end
  end

  always_comb begin
    if (i_flush) begin
      occ_d = '0;
    end else begin
      occ_d = occ_q + OCC_W'(alloc_fire) - fire_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        entry_q[i] <= '0;
      end
      occ_q <= '0;
    end else begin
      for (int i = 0; i < ENTRY_SIZE; i++) begin
        entry_q[i] <= entry_d[i];
      end
      occ_q <= occ_d;
    end
  end

  assign o_occupancy = occ_q;
  assign o_empty     = (occ_q == '0);

  a_occ_range: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    occ_q <= OCC_W'(ENTRY_SIZE));

  a_free_pick_consistent: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    alloc_fire |-> free_oh[free_idx]);

endmodule

// File: tb/tb_issue_entry_scheduler.sv
module tb_issue_entry_scheduler;
  import scariv_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [31:0] alloc_data;
  logic        alloc_src_ready;
  logic [5:0]  alloc_src_tag;
  logic        wakeup_valid;
  logic [5:0]  wakeup_tag;
  logic [1:0]  iss_valid;
  logic [31:0] iss_data [2];
  logic [1:0]  iss_ready;
  logic [3:0]  occupancy;
  logic        empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  issue_entry_scheduler dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_flush           (flush),
    .i_alloc_valid     (alloc_valid),
    .o_alloc_ready     (alloc_ready),
    .i_alloc_data      (alloc_data),
    .i_alloc_src_ready (alloc_src_ready),
    .i_alloc_src_tag   (alloc_src_tag),
    .i_wakeup_valid    (wakeup_valid),
    .i_wakeup_tag      (wakeup_tag),
    .o_iss_valid       (iss_valid),
    .o_iss_data        (iss_data),
    .i_iss_ready       (iss_ready),
    .o_occupancy       (occupancy),
    .o_empty           (empty)
  );

  typedef struct {
    logic        fl;
    logic        av;
    logic [31:0] ad;
    logic        sr;
    logic [5:0]  at;
    logic        wv;
    logic [5:0]  wt;
    logic [1:0]  ir;
    logic        e_ar;
    logic [1:0]  e_iv;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [3:0]  e_occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic fl, logic av, logic [31:0] ad, logic sr, logic [5:0] at,
                             logic wv, logic [5:0] wt, logic [1:0] ir, logic e_ar,
                             logic [1:0] e_iv, logic [31:0] e_d0, logic [31:0] e_d1,
                             logic [3:0] e_occ);
    vec_t r;
    r.fl = fl; r.av = av; r.ad = ad; r.sr = sr; r.at = at; r.wv = wv; r.wt = wt; r.ir = ir;
    r.e_ar = e_ar; r.e_iv = e_iv; r.e_d0 = e_d0; r.e_d1 = e_d1; r.e_occ = e_occ;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    flush = x.fl; alloc_valid = x.av; alloc_data = x.ad; alloc_src_ready = x.sr;
    alloc_src_tag = x.at; wakeup_valid = x.wv; wakeup_tag = x.wt; iss_ready = x.ir;
  endtask

  task automatic idle_inputs();
    drive(v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0));
  endtask

  task automatic check_vec(input int i, input vec_t x);
    chk($sformatf("v%0d alloc_ready", i), 32'(alloc_ready), 32'(x.e_ar));
    chk($sformatf("v%0d iss_valid", i), 32'(iss_valid), 32'(x.e_iv));
    if (x.e_iv[0]) chk($sformatf("v%0d iss_data0", i), iss_data[0], x.e_d0);
    if (x.e_iv[1]) chk($sformatf("v%0d iss_data1", i), iss_data[1], x.e_d1);
    chk($sformatf("v%0d occupancy", i), 32'(occupancy), 32'(x.e_occ));
    chk($sformatf("v%0d empty", i), 32'(empty), 32'(x.e_occ == 0));
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, " alloc_ready"}, 32'(alloc_ready), 32'd1);
    chk({tag, " iss_valid"}, 32'(iss_valid), 32'd0);
    chk({tag, " occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, " empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // fl av data sr tag wv wt ir | ar iv d0 d1 occ
    // three ready allocs, then drain over two ports
    vecs.push_back(v(0,1,32'hA,1,0,0,0,2'b00, 1,2'b00,0,0,0));
    vecs.push_back(v(0,1,32'hB,1,0,0,0,2'b00, 1,2'b01,32'hA,0,1));
    vecs.push_back(v(0,1,32'hC,1,0,0,0,2'b00, 1,2'b11,32'hA,32'hB,2));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,     1,2'b11,32'hA,32'hB,3));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,     1,2'b01,32'hC,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,     1,2'b00,0,0,0));
    // two entries waiting on tag 5, then wakeup
    vecs.push_back(v(0,1,32'h50,0,5,0,0,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(v(0,1,32'h51,0,5,0,0,2'b11, 1,2'b00,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,      1,2'b00,0,0,2));
    vecs.push_back(v(0,0,0,0,0,1,5,2'b11,      1,2'b00,0,0,2));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,      1,2'b11,32'h50,32'h51,2));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,      1,2'b00,0,0,0));
    // same-cycle wakeup bypass on tag 7
    vecs.push_back(v(0,1,32'h77,0,7,1,7,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,      1,2'b01,32'h77,0,1));
    // non-matching wakeups must not wake tag 3
    vecs.push_back(v(0,1,32'h33,0,3,1,4,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(v(0,0,0,0,0,1,2,2'b11,      1,2'b00,0,0,1));
    vecs.push_back(v(0,0,0,0,0,1,3,2'b11,      1,2'b00,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,      1,2'b01,32'h33,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,      1,2'b00,0,0,0));
    // port 0 stalled, port 1 drains
    vecs.push_back(v(0,1,32'h10,1,0,0,0,2'b00, 1,2'b00,0,0,0));
    vecs.push_back(v(0,1,32'h11,1,0,0,0,2'b00, 1,2'b01,32'h10,0,1));
    vecs.push_back(v(0,1,32'h12,1,0,0,0,2'b00, 1,2'b11,32'h10,32'h11,2));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b10,      1,2'b11,32'h10,32'h11,3));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b10,      1,2'b11,32'h10,32'h12,2));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b10,      1,2'b01,32'h10,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b01,      1,2'b01,32'h10,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,      1,2'b00,0,0,0));
    // fill all 8 with tag 1, not ready
    for (int k = 0; k < 8; k++)
      vecs.push_back(v(0,1,32'h80 + k,0,1,0,0,2'b00, 1,2'b00,0,0,4'(k)));
    vecs.push_back(v(0,1,32'hFF,1,0,0,0,2'b00,  0,2'b00,0,0,8));
    vecs.push_back(v(0,0,0,0,0,1,1,2'b00,       0,2'b00,0,0,8));
    // full: issue fires but alloc still refused
    vecs.push_back(v(0,1,32'hEE,1,0,0,0,2'b11,  0,2'b11,32'h80,32'h81,8));
    vecs.push_back(v(0,1,32'h90,1,0,0,0,2'b00,  1,2'b11,32'h82,32'h83,6));
    // lower-index entry 0 overtakes; fire both leaves 5 valid
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,       1,2'b11,32'h90,32'h82,7));
    // flush with alloc, wakeup and fire pending
    vecs.push_back(v(1,1,32'h91,1,0,1,1,2'b11,  1,2'b00,0,0,5));
    vecs.push_back(v(0,0,0,0,0,0,0,2'b11,       1,2'b00,0,0,0));

    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check_idle_reset("reset");
    chk("reset iss_data0", iss_data[0], 32'd0);
    chk("reset iss_data1", iss_data[1], 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #4;
      check_vec(i, vecs[i]);
      $display("vec %0d: iv=%b d0=%0h d1=%0h occ=%0d ar=%b", i, iss_valid, iss_data[0],
               iss_data[1], occupancy, alloc_ready);
      @(posedge clk);
      #1;
    end

    // asynchronous reset in the middle of operation
    drive(v(0,1,32'hC1,1,0,0,0,2'b00, 0,0,0,0,0));
    @(posedge clk); #1;
    drive(v(0,1,32'hC2,1,0,0,0,2'b00, 0,0,0,0,0));
    @(posedge clk); #1;
    idle_inputs();
    #2;
    chk("pre_rst iss_valid", 32'(iss_valid), 32'd3);
    chk("pre_rst iss_data1", iss_data[1], 32'hC2);
    rst_n = 1'b0;
    #1;
    check_idle_reset("async_rst");
    chk("async_rst iss_data0", iss_data[0], 32'd0);
    iss_ready = 2'b11;
    @(posedge clk); #1;
    chk("in_rst iss_valid", 32'(iss_valid), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check_idle_reset("post_rst");
    $display("async reset: iv=%b occ=%0d", iss_valid, occupancy);
    @(posedge clk); #1;
    drive(v(0,1,32'hD1,1,0,0,0,2'b00, 0,0,0,0,0));
    @(posedge clk); #1;
    idle_inputs();
    #2;
    chk("post_rst alloc iss_valid", 32'(iss_valid), 32'd1);
    chk("post_rst alloc iss_data0", iss_data[0], 32'hD1);
    chk("post_rst alloc occupancy", 32'(occupancy), 32'd1);
    $display("post reset alloc: iv=%b d0=%0h occ=%0d", iss_valid, iss_data[0], occupancy);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_entry_scheduler.md
# issue_entry_scheduler

Holds up to ENTRY_SIZE dispatched operations, tracks one pending source tag per entry, and issues up to ISS_PORTS ready operations per cycle. Port p is given the p-th ready entry in index order, lowest index first. It sits between dispatch and the execution pipes of a SCARIV issue unit. It is the controller that sequences the N-th-valid picker datapath for both free-slot allocation and issue selection.

## Interface
- ENTRY_SIZE, 8: number of entries; at least 2.
- ISS_PORTS, 2: number of issue ports; 1..ENTRY_SIZE.
- DATA_WIDTH, 32: payload width.
- TAG_W, 6: wakeup tag width.
- i_clk  in  1  clock; the only clock.
- i_reset_n  in  1  reset, asynchronous, active-low.
- i_flush  in  1  kill all entries.
- i_alloc_valid  in  1  dispatch request.
- o_alloc_ready  out  1  at least one free entry exists.
- i_alloc_data  in  DATA_WIDTH  payload.
- i_alloc_src_ready  in  1  source operand already available.
- i_alloc_src_tag  in  TAG_W  tag waited on when not ready.
- i_wakeup_valid  in  1  wakeup broadcast.
- i_wakeup_tag  in  TAG_W  broadcast tag.
- o_iss_valid  out  ISS_PORTS  per-port issue valid.
- o_iss_data  out  DATA_WIDTH x ISS_PORTS  unpacked array of payloads.
- i_iss_ready  in  ISS_PORTS  per-port pipe acceptance.
- o_occupancy  out  $clog2(ENTRY_SIZE+1)  number of valid entries.
- o_empty  out  1  o_occupancy == 0.

## Operation
- Each entry state is {valid, ready, tag, data}. On reset every entry has valid=0 and ready=0.
- **Allocation**
  - The target is the lowest-index free entry, computed from registered state.
  - o_alloc_ready = |~valid. It is combinational and independent of i_alloc_valid.
  - The entry is written when i_alloc_valid && o_alloc_ready && !i_flush.
  - The new entry's ready = i_alloc_src_ready || (i_wakeup_valid && i_wakeup_tag == i_alloc_src_tag). This is a same-cycle bypass.
- **Wakeup**
  - Every valid, non-ready entry whose tag equals i_wakeup_tag sets ready=1 on the next edge.
  - Multiple entries may wake together.
- **Pick**
  - rdy_vec = valid & ready, taken from registered state.
  - Port p selects the p-th set bit of rdy_vec, with p counting from 0.
  - o_iss_valid[p] = that pick exists && !i_flush.
  - o_iss_data[p] is the selected entry's data. It is don't-care when o_iss_valid[p]=0.
  - Ports are independent: port 1 may fire while port 0 stalls.
  - A stalled pick re-presents the same entry next cycle unless a lower-index entry became ready, in which case the picks shift. Issue order is by index, not age.
- **Release**
  - An entry is cleared (valid=0, ready=0) on the edge where its port has o_iss_valid && i_iss_ready.
  - A released slot may be reallocated in the next cycle, not the same cycle.
- **Flush**
  - All entries are cleared on the next edge.
  - Allocation and issue fires in the flush cycle are discarded.
  - A wakeup in the flush cycle has no effect.
- **Occupancy**
  - o_occupancy is a register: next = cur + alloc_fire - popcount(iss_fire). It is 0 after reset or flush.
  - The count never leaves the range 0..ENTRY_SIZE. An assertion checks this.

## Timing
- Reset values: o_alloc_ready=1, o_iss_valid=0, o_occupancy=0, o_empty=1, o_iss_data=0.
- Alloc to issue latency:
  - Allocated with ready=1 at edge N: o_iss_valid can be asserted in cycle N+1 at the earliest.
  - Wakeup at edge N: the entry can issue in cycle N+1.
- A fire at edge N frees the slot, and o_alloc_ready reflects the freed slot in cycle N+1.
- Full, all ENTRY_SIZE valid: o_alloc_ready=0 even if an issue fires in the same cycle.
- An asynchronous reset mid-operation clears all state immediately. No issue is generated until after reset deasserts.

## Structure
- Package scariv_sched_pkg holds:
  - typedef sched_entry_t {valid, ready, tag, data}, parameterised via package constants.
  - the occupancy width function.
- Sub-module bit_pick_1_index is instantiated:
  - ISS_PORTS times, NUM=p, over rdy_vec with entry data, for the issue picks;
  - once, NUM=0, over ~valid, for the free-slot pick (use o_picked_pos as the write one-hot).
- Wrapper logic: entry registers, wakeup compare, release one-hot OR, occupancy counter, flush.

## Test plan
- Reset, then 3 allocs with src_ready=1 and data 0xA,0xB,0xC, all i_iss_ready=1:
  - cycle N+1 issues 0xA on port 0 and 0xB on port 1;
  - the next cycle issues 0xC on port 0;
  - o_occupancy returns to 0.
- Alloc 2 entries with tag 5 not ready, then wakeup tag 5:
  - neither entry issues before the wakeup;
  - both issue in the cycle after the wakeup edge.
- Alloc with tag 7 while i_wakeup_tag=7 in the same cycle: the entry issues the next cycle via the bypass.
- Fill all 8 entries with src_ready=0:
  - o_alloc_ready=0;
  - an alloc attempt is dropped and occupancy stays 8.
- Port 0 i_iss_ready=0, port 1 ready, entries 0..2 ready:
  - port 1 drains entry 1, then entry 2;
  - port 0 holds entry 0 until ready.
- 5 valid entries plus alloc, wakeup and fire all in the same cycle as i_flush=1:
  - the next cycle shows occupancy 0, o_empty=1, no o_iss_valid, o_alloc_ready=1.
